// File: rtl/pcie_fc_pkg.sv
// pcie_fc_pkg: shared FSM encoding and payload-size legality helpers for the completion path.
package pcie_fc_pkg;
    typedef enum logic [1:0] {IDLE, CALC, WAIT_BUF, ISSUE} cpl_state_t;
    localparam int MPS_MIN = 128;
    localparam int MPS_MID = 256;
    localparam int MPS_MAX = 512;
    function automatic bit mps_legal(input int mps);
        return (mps == MPS_MIN) || (mps == MPS_MID) || (mps == MPS_MAX);
    endfunction
endpackage

// File: rtl/cpl_chunk_calc.sv
// cpl_chunk_calc: sizes the next completion so it never crosses a payload-size boundary.
module cpl_chunk_calc #(
    parameter int MPS_DW = 64
) (
    input  logic [10:0] remaining,
    input  logic [9:0]  cur_dw,
    output logic [10:0] chunk,
    output logic [12:0] byte_count,
    output logic [6:0]  lower_addr
);
    logic [10:0] room;
    assign room       = 11'(MPS_DW) - {1'b0, cur_dw & 10'(MPS_DW - 1)};
    assign chunk      = (remaining < room) ? remaining : room;
    assign byte_count = {remaining, 2'b00};
    assign lower_addr = {cur_dw[4:0], 2'b00};
endmodule

// File: rtl/cpl_split_controller.sv
// cpl_split_controller: splits memory-read requests into payload-size bounded completion descriptors.
module cpl_split_controller
    import pcie_fc_pkg::*;
#(
    parameter int MAX_PAYLOAD_SIZE = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [10:0] req_len_i,
    input  logic [11:0] req_addr_i,
    input  logic [5:0]  trn_tbuf_av_i,
    output logic        cpl_valid_o,
    input  logic        cpl_ready_i,
    output logic [10:0] cpl_len_o,
    output logic [12:0] cpl_byte_count_o,
    output logic [6:0]  cpl_lower_addr_o,
    output logic        cpl_last_o,
    output logic [31:0] cpl_sent_o
);
    localparam int MPS_DW = MAX_PAYLOAD_SIZE / 4;

    if (!mps_legal(MAX_PAYLOAD_SIZE)) begin : g_bad_mps
        $error("MAX_PAYLOAD_SIZE must be 128, 256 or 512");
    end

    cpl_state_t  state;
    logic [10:0] remaining;
    logic [9:0]  cur_dw;
    logic [10:0] chunk;
    logic [12:0] byte_count;
    logic [6:0]  lower_addr;
    logic        unused_addr;

    assign unused_addr = ^req_addr_i[1:0];

    cpl_chunk_calc #(.MPS_DW(MPS_DW)) u_calc (
        .remaining  (remaining),
        .cur_dw     (cur_dw),
        .chunk      (chunk),
        .byte_count (byte_count),
        .lower_addr (lower_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            req_ready_o      <= 1'b1;
            cpl_valid_o      <= 1'b0;
            cpl_len_o        <= '0;
            cpl_byte_count_o <= '0;
            cpl_lower_addr_o <= '0;
            cpl_last_o       <= 1'b0;
            cpl_sent_o       <= '0;
            remaining        <= '0;
            cur_dw           <= '0;
        end else if (init_rst_i) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            cpl_valid_o <= 1'b0;
            cpl_sent_o  <= '0;
            remaining   <= '0;
            cur_dw      <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid_i) begin
                    remaining   <= (req_len_i == 11'd0) ? 11'd1024 : req_len_i;
                    cur_dw      <= req_addr_i[11:2];
                    req_ready_o <= 1'b0;
                    state       <= CALC;
                end
                CALC: begin
                    cpl_len_o        <= chunk;
                    cpl_byte_count_o <= byte_count;
                    cpl_lower_addr_o <= lower_addr;
                    cpl_last_o       <= (chunk == remaining);
                    state            <= WAIT_BUF;
                end
                WAIT_BUF: if (trn_tbuf_av_i > 6'd1) begin
                    cpl_valid_o <= 1'b1;
                    state       <= ISSUE;
                end
                ISSUE: if (cpl_ready_i) begin
                    // chunk never exceeds MPS_DW, so its low ten bits carry the whole advance
                    cpl_valid_o <= 1'b0;
                    remaining   <= remaining - cpl_len_o;
                    cur_dw      <= cur_dw + cpl_len_o[9:0];
                    cpl_sent_o  <= cpl_sent_o + 32'd1;
                    req_ready_o <= cpl_last_o;
                    state       <= cpl_last_o ? IDLE : CALC;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpl_split_controller.sv
// tb_cpl_split_controller: directed checks of request splitting, buffer gating, backpressure and resets.
module tb_cpl_split_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_rst_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [10:0] req_len_i = '0;
    logic [11:0] req_addr_i = '0;
    logic [5:0]  trn_tbuf_av_i = 6'd8;
    logic        cpl_valid_o;
    logic        cpl_ready_i = 1'b1;
    logic [10:0] cpl_len_o;
    logic [12:0] cpl_byte_count_o;
    logic [6:0]  cpl_lower_addr_o;
    logic        cpl_last_o;
    logic [31:0] cpl_sent_o;

    int total = 0;
    int bad = 0;

    cpl_split_controller #(.MAX_PAYLOAD_SIZE(256)) dut (
        .clk              (clk),
        .rst              (rst),
        .init_rst_i       (init_rst_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_len_i        (req_len_i),
        .req_addr_i       (req_addr_i),
        .trn_tbuf_av_i    (trn_tbuf_av_i),
        .cpl_valid_o      (cpl_valid_o),
        .cpl_ready_i      (cpl_ready_i),
        .cpl_len_o        (cpl_len_o),
        .cpl_byte_count_o (cpl_byte_count_o),
        .cpl_lower_addr_o (cpl_lower_addr_o),
        .cpl_last_o       (cpl_last_o),
        .cpl_sent_o       (cpl_sent_o)
    );

    always #5 clk = ~clk;

    task automatic do_init();
        @(negedge clk);
        init_rst_i = 1'b1;
        @(negedge clk);
        init_rst_i = 1'b0;
    endtask

    task automatic send_req(input logic [10:0] len, input logic [11:0] addr);
        @(negedge clk);
        req_valid_i = 1'b1;
        req_len_i   = len;
        req_addr_i  = addr;
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (cpl_valid_o) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({req_ready_o, cpl_valid_o, cpl_len_o, cpl_byte_count_o, cpl_lower_addr_o, cpl_last_o, cpl_sent_o}
            !== {1'b1, 1'b0, 11'd0, 13'd0, 7'd0, 1'b0, 32'd0}) begin
            bad++;
            $display("FAIL reset: rdy=%0b vld=%0b len=%0d bc=%0d la=%0h last=%0b sent=%0d want rdy=1 others 0",
                     req_ready_o, cpl_valid_o, cpl_len_o, cpl_byte_count_o, cpl_lower_addr_o, cpl_last_o, cpl_sent_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_init();
        send_req(11'd16, 12'h000);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (cpl_valid_o !== (i == 2)) begin
                bad++;
                $display("FAIL latency cycle %0d: valid=%0b want %0b", i, cpl_valid_o, i == 2);
            end
            if (i < 2) @(negedge clk);
        end
        total++;
        if ({cpl_len_o, cpl_byte_count_o, cpl_lower_addr_o, cpl_last_o} !== {11'd16, 13'd64, 7'h00, 1'b1}) begin
            bad++;
            $display("FAIL single fields: len=%0d bc=%0d la=%0h last=%0b want 16 64 0 1",
                     cpl_len_o, cpl_byte_count_o, cpl_lower_addr_o, cpl_last_o);
        end
        @(negedge clk);
        total++;
        if (cpl_sent_o !== 32'd1 || cpl_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL single done: sent=%0d vld=%0b rdy=%0b want 1 0 1", cpl_sent_o, cpl_valid_o, req_ready_o);
        end
    endtask

    task automatic test_split();
        logic [10:0] e_len [3] = '{11'd4, 11'd64, 11'd32};
        logic [12:0] e_bc  [3] = '{13'd400, 13'd384, 13'd128};
        logic [6:0]  e_la  [3] = '{7'h70, 7'h00, 7'h00};
        bit ok;
        do_init();
        send_req(11'd100, 12'h0F0);
        for (int i = 0; i < 3; i++) begin
            wait_valid(ok);
            total++;
            if (!ok || {cpl_len_o, cpl_byte_count_o, cpl_lower_addr_o, cpl_last_o} !== {e_len[i], e_bc[i], e_la[i], i == 2}) begin
                bad++;
                $display("FAIL split cpl%0d: ok=%0b len=%0d bc=%0d la=%0h last=%0b want %0d %0d %0h %0b",
                         i, ok, cpl_len_o, cpl_byte_count_o, cpl_lower_addr_o, cpl_last_o, e_len[i], e_bc[i], e_la[i], i == 2);
            end
            @(negedge clk);
        end
        total++;
        if (cpl_sent_o !== 32'd3) begin
            bad++;
            $display("FAIL split sent: got %0d want 3", cpl_sent_o);
        end
    endtask

    task automatic test_max();
        bit ok;
        do_init();
        send_req(11'd0, 12'h000);
        for (int i = 0; i < 16; i++) begin
            wait_valid(ok);
            total++;
            if (!ok || {cpl_len_o, cpl_byte_count_o, cpl_lower_addr_o, cpl_last_o} !== {11'd64, 13'(4096 - 256 * i), 7'h00, i == 15}) begin
                bad++;
                $display("FAIL max cpl%0d: ok=%0b len=%0d bc=%0d la=%0h last=%0b want 64 %0d 0 %0b",
                         i, ok, cpl_len_o, cpl_byte_count_o, cpl_lower_addr_o, cpl_last_o, 4096 - 256 * i, i == 15);
            end
            @(negedge clk);
        end
        total++;
        if (cpl_sent_o !== 32'd16) begin
            bad++;
            $display("FAIL max sent: got %0d want 16", cpl_sent_o);
        end
    endtask

    task automatic test_buf_gate();
        int early = 0;
        do_init();
        trn_tbuf_av_i = 6'd1;
        send_req(11'd16, 12'h000);
        repeat (10) begin
            if (cpl_valid_o !== 1'b0) early++;
            @(negedge clk);
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL buf gate: valid high %0d of 10 cycles want 0", early);
        end
        trn_tbuf_av_i = 6'd2;
        @(negedge clk);
        total++;
        if (cpl_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL buf release: valid=%0b want 1", cpl_valid_o);
        end
        trn_tbuf_av_i = 6'd8;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit ok;
        int drift = 0;
        do_init();
        cpl_ready_i = 1'b0;
        send_req(11'd16, 12'h040);
        wait_valid(ok);
        trn_tbuf_av_i = 6'd0;
        repeat (5) begin
            if (!ok || {cpl_valid_o, cpl_len_o, cpl_byte_count_o, cpl_lower_addr_o, cpl_last_o}
                !== {1'b1, 11'd16, 13'd64, 7'h40, 1'b1}) drift++;
            @(negedge clk);
        end
        total++;
        if (drift != 0) begin
            bad++;
            $display("FAIL backpressure hold: %0d unstable cycles want 0 (vld=%0b len=%0d bc=%0d la=%0h)",
                     drift, cpl_valid_o, cpl_len_o, cpl_byte_count_o, cpl_lower_addr_o);
        end
        cpl_ready_i = 1'b1;
        @(negedge clk);
        total++;
        if (cpl_valid_o !== 1'b0 || cpl_sent_o !== 32'd1) begin
            bad++;
            $display("FAIL backpressure handshake: vld=%0b sent=%0d want 0 1", cpl_valid_o, cpl_sent_o);
        end
        trn_tbuf_av_i = 6'd8;
    endtask

    task automatic test_ignore_req();
        bit ok;
        do_init();
        send_req(11'd100, 12'h0F0);
        req_valid_i = 1'b1;
        req_len_i   = 11'd16;
        req_addr_i  = 12'h000;
        total++;
        if (req_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL busy ready: got %0b want 0", req_ready_o);
        end
        wait_valid(ok);
        total++;
        if (!ok || cpl_len_o !== 11'd4 || cpl_byte_count_o !== 13'd400) begin
            bad++;
            $display("FAIL busy cpl0: ok=%0b len=%0d bc=%0d want 4 400", ok, cpl_len_o, cpl_byte_count_o);
        end
        @(negedge clk);
        wait_valid(ok);
        total++;
        if (!ok || cpl_len_o !== 11'd64 || cpl_byte_count_o !== 13'd384) begin
            bad++;
            $display("FAIL busy cpl1: ok=%0b len=%0d bc=%0d want 64 384", ok, cpl_len_o, cpl_byte_count_o);
        end
        req_valid_i = 1'b0;
        @(negedge clk);
        wait_valid(ok);
        total++;
        if (!ok || cpl_len_o !== 11'd32 || cpl_byte_count_o !== 13'd128 || cpl_last_o !== 1'b1) begin
            bad++;
            $display("FAIL busy cpl2: ok=%0b len=%0d bc=%0d last=%0b want 32 128 1", ok, cpl_len_o, cpl_byte_count_o, cpl_last_o);
        end
        @(negedge clk);
    endtask

    task automatic test_init_priority();
        bit ok;
        int extra = 0;
        send_req(11'd100, 12'h0F0);
        wait_valid(ok);
        init_rst_i = 1'b1;
        @(negedge clk);
        init_rst_i = 1'b0;
        total++;
        if (!ok || cpl_valid_o !== 1'b0 || cpl_sent_o !== 32'd0 || req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL init priority: ok=%0b vld=%0b sent=%0d rdy=%0b want 0 0 1", ok, cpl_valid_o, cpl_sent_o, req_ready_o);
        end
        repeat (10) begin
            @(negedge clk);
            if (cpl_valid_o !== 1'b0) extra++;
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL init discard: valid high %0d cycles want 0", extra);
        end
    endtask

    task automatic test_rst_abort();
        bit ok;
        int extra = 0;
        do_init();
        send_req(11'd0, 12'h000);
        for (int i = 0; i < 2; i++) begin
            wait_valid(ok);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        total++;
        if (!ok || {req_ready_o, cpl_valid_o, cpl_len_o, cpl_byte_count_o, cpl_lower_addr_o, cpl_last_o, cpl_sent_o}
            !== {1'b1, 1'b0, 11'd0, 13'd0, 7'd0, 1'b0, 32'd0}) begin
            bad++;
            $display("FAIL rst abort: ok=%0b rdy=%0b vld=%0b len=%0d bc=%0d la=%0h last=%0b sent=%0d want rdy=1 others 0",
                     ok, req_ready_o, cpl_valid_o, cpl_len_o, cpl_byte_count_o, cpl_lower_addr_o, cpl_last_o, cpl_sent_o);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (cpl_valid_o !== 1'b0 || req_ready_o !== 1'b1) extra++;
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL rst quiet: %0d cycles with valid or not ready want 0", extra);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_split();
        test_max();
        test_buf_gate();
        test_backpressure();
        test_ignore_req();
        test_init_priority();
        test_rst_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
